// File: rtl/scalar_add_ctrl_pkg.sv
// ============================================================================
// scalar_add_ctrl_pkg : shared types and constants for scalar_add_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package scalar_add_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_WRITE  = 2'd1,
        OP_READ   = 2'd2,
        OP_LAUNCH = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ID_A   = 2'd0,
        ID_B   = 2'd1,
        ID_Y   = 2'd2,
        ID_CNT = 2'd3
    } id_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam logic [31:0] NOP_PATTERN = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/scalar_add_ctrl_if.sv
// ============================================================================
// scalar_add_ctrl_if : host command/response port plus adder handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface scalar_add_ctrl_if #(
    parameter int DATA_W = 32
);
    import scalar_add_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    opcode_e           cmd_opcode;
    id_e               cmd_id;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              add_start;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic              add_done;
    logic [DATA_W-1:0] add_y;

    // Host side plus the adder datapath: everything the controller consumes
    modport master (
        output cmd_valid, cmd_opcode, cmd_id, cmd_data, rsp_ready, add_done, add_y,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, add_start, add_a, add_b
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_id, cmd_data, rsp_ready, add_done, add_y,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, add_start, add_a, add_b
    );

endinterface

`default_nettype wire

// File: rtl/scalar_add_ctrl_timer.sv
// ============================================================================
// scalar_add_ctrl_timer : clear/enable wait counter, flags expiry at TIMEOUT
// Revision: 1.0
// ============================================================================
`default_nettype none

module scalar_add_ctrl_timer #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != C_LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/scalar_add_ctrl.sv
// ============================================================================
// scalar_add_ctrl : command sequencer owning A/B/Y/CNT for the scalar_add datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module scalar_add_ctrl
    import scalar_add_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    scalar_add_ctrl_if.slave   bus
);
    localparam logic [DATA_W-1:0] C_NOP = DATA_W'(NOP_PATTERN);

    state_e            state_q, state_d;
    opcode_e           op_q, op_d;
    id_e               id_q, id_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, y_q, y_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timer_clear, timer_en, timer_expired;

    scalar_add_ctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        wdata_d     = wdata_q;
        a_d         = a_q;
        b_d         = b_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_opcode;
                    id_d    = bus.cmd_id;
                    wdata_d = bus.cmd_data;
                    state_d = (bus.cmd_opcode == OP_LAUNCH) ? ST_START : ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                unique case (op_q)
                    OP_NOP:   rsp_data_d = C_NOP;
                    OP_WRITE: begin
                        unique case (id_q)
                            ID_A:   a_d = wdata_q;
                            ID_B:   b_d = wdata_q;
                            ID_Y:   y_d = wdata_q;
                            ID_CNT: rsp_err_d = 1'b1;
                        endcase
                    end
                    OP_READ: begin
                        unique case (id_q)
                            ID_A:   rsp_data_d = a_q;
                            ID_B:   rsp_data_d = b_q;
                            ID_Y:   rsp_data_d = y_q;
                            ID_CNT: rsp_data_d = cnt_q;
                        endcase
                    end
                    OP_LAUNCH: rsp_err_d = 1'b1;
                endcase
                state_d = ST_RESP;
            end
            ST_START: begin
                timer_clear = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving together with expiry still counts as success
                if (bus.add_done) begin
                    y_d        = bus.add_y;
                    cnt_d      = cnt_q + DATA_W'(1);
                    rsp_data_d = bus.add_y;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (timer_expired) begin
                    rsp_data_d = C_NOP;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            id_q       <= ID_A;
            wdata_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            id_q       <= id_d;
            wdata_q    <= wdata_d;
            a_q        <= a_d;
            b_q        <= b_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.add_start = (state_q == ST_START);
    assign bus.add_a     = a_q;
    assign bus.add_b     = b_q;

endmodule

`default_nettype wire

// File: tb/tb_scalar_add_ctrl.sv
// ============================================================================
// tb_scalar_add_ctrl : directed stimulus with a queued response scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scalar_add_ctrl;
    import scalar_add_ctrl_pkg::*;

    localparam int TMO = 20;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    scalar_add_ctrl_if #(.DATA_W(32)) bus ();

    scalar_add_ctrl #(.DATA_W(32), .TIMEOUT(TMO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   errors = 0;
    int   checks = 0;
    rsp_t sb[$];

    // Adder model controls
    int          done_delay = 0;
    int          starts     = 0;
    logic [31:0] exp_a = '0, exp_b = '0;
    logic        model_done = 1'b0, spur_done = 1'b0;
    logic [31:0] model_y = '0;

    assign bus.add_done = model_done | spur_done;
    assign bus.add_y    = spur_done ? 32'd77 : model_y;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops one expectation per completed handshake
    always @(negedge clock) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_data", bus.rsp_data, e.data);
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Adder datapath model
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && bus.add_start === 1'b1) begin
                starts++;
                check("add_a", bus.add_a, exp_a);
                check("add_b", bus.add_b, exp_b);
                if (done_delay > 0) begin
                    repeat (done_delay) @(posedge clock);
                    #1;
                    model_done = 1'b1;
                    model_y    = exp_a + exp_b;
                    @(posedge clock);
                    #1;
                    model_done = 1'b0;
                end
            end
        end
    end

    task automatic send(input opcode_e op, input id_e id, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee);
        rsp_t e;
        bit   acc;
        e.data = ed;
        e.err  = ee;
        sb.push_back(e);
        acc = 1'b0;
        @(posedge clock);
        #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_id     = id;
        bus.cmd_data   = d;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (bus.cmd_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        if (!acc) check("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = OP_NOP;
        bus.cmd_id     = ID_A;
        bus.cmd_data   = '0;
        bus.rsp_ready  = 1'b1;

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("rst_add_start", {31'd0, bus.add_start}, 32'd0);

        send(OP_READ, ID_A, 0, 32'd0, 1'b0);
        send(OP_READ, ID_B, 0, 32'd0, 1'b0);
        send(OP_READ, ID_Y, 0, 32'd0, 1'b0);
        send(OP_READ, ID_CNT, 0, 32'd0, 1'b0);
        drain();

        // Successful add with done three cycles after start
        send(OP_WRITE, ID_A, 32'd5, 32'd0, 1'b0);
        send(OP_WRITE, ID_B, 32'd7, 32'd0, 1'b0);
        exp_a = 32'd5; exp_b = 32'd7; done_delay = 3;
        send(OP_LAUNCH, ID_A, 0, 32'd12, 1'b0);
        drain();
        check("start_pulses_1", starts, 1);
        send(OP_READ, ID_Y, 0, 32'd12, 1'b0);
        send(OP_READ, ID_CNT, 0, 32'd1, 1'b0);
        drain();

        // Timeout: done never arrives
        done_delay = 0;
        send(OP_LAUNCH, ID_A, 0, 32'hDEADBEEF, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 4 * TMO) begin
            @(negedge clock);
            n++;
        end
        check("timeout_min_wait", {31'd0, n >= TMO}, 32'd1);
        check("timeout_max_wait", {31'd0, n <= TMO + 4}, 32'd1);
        drain();
        check("start_pulses_2", starts, 2);
        send(OP_READ, ID_Y, 0, 32'd12, 1'b0);
        send(OP_READ, ID_CNT, 0, 32'd1, 1'b0);
        send(OP_NOP, ID_A, 0, 32'hDEADBEEF, 1'b0);
        drain();

        // Write to read-only CNT is rejected and disturbs nothing
        send(OP_WRITE, ID_CNT, 32'd55, 32'd0, 1'b1);
        send(OP_READ, ID_A, 0, 32'd5, 1'b0);
        send(OP_READ, ID_B, 0, 32'd7, 1'b0);
        send(OP_READ, ID_Y, 0, 32'd12, 1'b0);
        send(OP_READ, ID_CNT, 0, 32'd1, 1'b0);
        drain();

        // Backpressure with a competing command held on the port
        bus.rsp_ready = 1'b0;
        send(OP_READ, ID_A, 0, 32'd5, 1'b0);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = OP_WRITE;
        bus.cmd_id     = ID_A;
        bus.cmd_data   = 32'd99;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_rsp_data", bus.rsp_data, 32'd5);
            check("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        end
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();
        send(OP_READ, ID_A, 0, 32'd5, 1'b0);
        drain();

        // Spurious done while idle
        @(posedge clock);
        #1 spur_done = 1'b1;
        @(posedge clock);
        #1 spur_done = 1'b0;
        send(OP_READ, ID_Y, 0, 32'd12, 1'b0);
        send(OP_READ, ID_CNT, 0, 32'd1, 1'b0);
        drain();

        // Reset while waiting for done
        done_delay = 0;
        send(OP_LAUNCH, ID_A, 0, 32'hDEADBEEF, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_add_start", {31'd0, bus.add_start}, 32'd0);
        check("mid_rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        send(OP_READ, ID_CNT, 0, 32'd0, 1'b0);
        send(OP_READ, ID_A, 0, 32'd0, 1'b0);
        send(OP_WRITE, ID_A, 32'd100, 32'd0, 1'b0);
        send(OP_WRITE, ID_B, 32'd23, 32'd0, 1'b0);
        drain();
        exp_a = 32'd100; exp_b = 32'd23; done_delay = 3;
        send(OP_LAUNCH, ID_A, 0, 32'd123, 1'b0);
        send(OP_READ, ID_CNT, 0, 32'd1, 1'b0);
        send(OP_READ, ID_Y, 0, 32'd123, 1'b0);
        drain();

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
